ram_arb: RTL and testbench
==========================

# ram_arb

Two-requester arbiter that shares the single data port of the unified RAM between the UART host loader (byte-wide, driven by the command decoder) and the hxd32 CPU data port (word-wide). It sits between those two masters and the RAM, and owns three functions: round-robin arbitration, byte-lane steering of host accesses, and routing of read data back to whichever requester issued the read. Host exclusive mode gives the loader sole access while the CPU is held in reset.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- host_excl_i  in  1  host exclusive mode; CPU never granted (tie to ~cpu_rst_n).
- host_req_i  in  1  host access request.
- host_we_i  in  1  1 = write, 0 = read.
- host_addr_i  in  XLEN  host byte address.
- host_wr_data_i  in  8  host write byte.
- host_gnt_o  out  1  host grant.
- host_rd_data_o  out  8  host read byte.
- host_rd_vld_o  out  1  host read data valid.
- cpu_req_i  in  1  CPU access request.
- cpu_we_i  in  1  1 = write.
- cpu_addr_i  in  XLEN  CPU byte address; bits [1:0] are ignored.
- cpu_wr_data_i  in  XLEN  CPU write word.
- cpu_byte_en_i  in  4  CPU write byte enables.
- cpu_gnt_o  out  1  CPU grant.
- cpu_rd_data_o  out  XLEN  CPU read word.
- cpu_rd_vld_o  out  1  CPU read data valid.
- mem_en_o  out  1  RAM access strobe.
- mem_we_o  out  4  RAM byte write enables.
- mem_addr_o  out  XLEN-2  RAM word address.
- mem_wr_data_o  out  XLEN  RAM write data.
- mem_rd_data_i  in  XLEN  RAM read data; valid the cycle after a read strobe.
- stall_cnt_o  out  16  saturating count of CPU stall cycles.

## Operation
- **Transfer.** A transfer occurs on any rising edge where req && gnt. Requesters hold the request and all request fields stable until granted.
- **Grant logic.** Grants are combinational from the requests and the registered last-winner pointer `last_host`.
  - host_excl_i = 1: host_gnt_o = host_req_i; cpu_gnt_o = 0.
  - Only one requester active: it is granted.
  - Both active: the requester that did not win the last granted transfer wins. `last_host` updates on every granted transfer.
- **Host steering.**
  - mem_addr_o = host_addr_i[XLEN-1:2].
  - mem_wr_data_o = {4{host_wr_data_i}}.
  - mem_we_o = host_we_i ? (4'b0001 << host_addr_i[1:0]) : 0.
- **CPU steering.**
  - mem_addr_o = cpu_addr_i[XLEN-1:2].
  - mem_wr_data_o = cpu_wr_data_i.
  - mem_we_o = cpu_we_i ? cpu_byte_en_i : 0.
- **Strobe.** mem_en_o = host_gnt_o | cpu_gnt_o. With no grant, mem_we_o = 0 and address/data hold the host fields (don't-care).
- **Read return tracking.** On a granted read, register the owner (host/CPU) and, for the host, its byte lane host_addr_i[1:0]; set `rd_pend`. The following cycle:
  - owner's rd_vld_o = rd_pend.
  - cpu_rd_data_o = mem_rd_data_i.
  - host_rd_data_o = mem_rd_data_i[8*lane +: 8].
  - `rd_pend` reloads each cycle from the current grant, so back-to-back reads, including alternating owners, return in order, one per cycle.
- **Stall counter.** stall_cnt_o increments each cycle with cpu_req_i && !cpu_gnt_o, including exclusive mode. It saturates at 16'hFFFF and clears only on reset.

## Timing
- **Reset values.**
  - host_rd_vld_o, cpu_rd_vld_o = 0.
  - stall_cnt_o = 0.
  - `rd_pend` = 0.
  - `last_host` = 0, so the host wins the first tie.
  - Grants and mem_en_o follow the requests combinationally once out of reset.
- **Latency.**
  - Grant: 0 cycles after the request.
  - Write committed to RAM: at the grant edge.
  - Read data: rd_vld_o high exactly 1 cycle after the grant edge, for 1 cycle.
- **Throughput.** One transfer per cycle. With both requesters continuously active, grants alternate every cycle and each gets 50 %.
- **host_excl_i change.**
  - Takes effect the same cycle.
  - A CPU read granted in the previous cycle still returns cpu_rd_vld_o.
  - `last_host` is unaffected by exclusive-mode grants that occur with no competition.
- **Read then write to the same address on consecutive cycles.** The read returns the old value, provided the RAM is read-first.
- **Reset mid-operation.** Asserting rst_n_i clears `rd_pend` asynchronously; no rd_vld_o pulse appears after reset, even when a read was granted in the prior cycle.

## Test plan
1. Host write byte 8'hAA at address 0x106 → mem_addr_o = 0x41, mem_we_o = 4'b0100, mem_wr_data_o = 32'hAAAAAAAA. A host read of 0x106 one cycle later → host_rd_vld_o high next cycle, host_rd_data_o = 8'hAA.
2. CPU and host both request continuously for 8 cycles starting from reset → grants H,C,H,C,H,C,H,C; stall_cnt_o = 4.
3. Alternating reads host@0x0, CPU@0x4, host@0x3 with RAM word0 = 32'h11223344 and word1 = 32'hDEADBEEF → vld sequence host(8'h44), CPU(32'hDEADBEEF), host(8'h11) on consecutive cycles.
4. host_excl_i = 1, cpu_req_i held high for 20 cycles, no host request → cpu_gnt_o stays 0, stall_cnt_o = 20, mem_en_o = 0.
5. CPU read granted, then rst_n_i asserted before the next edge → cpu_rd_vld_o stays 0; all outputs at reset values.
6. Stall counter preloaded near saturation by 70000 stall cycles → holds at 16'hFFFF.

Source files
------------

// File: rtl/ram_arb.sv
// ram_arb: shares the single data port of the unified RAM between the
// byte-wide UART host loader and the word-wide hxd32 CPU data port.
//
// Functions:
//   - round-robin arbitration between host and CPU (host exclusive mode
//     locks the CPU out while it is held in reset)
//   - byte-lane steering of host accesses onto the 32-bit RAM port
//   - routing of RAM read data back to whichever requester issued the read
//   - saturating count of CPU stall cycles
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   host_excl_i               host exclusive mode (CPU never granted)
//   host_*                    host request/grant/read-return (byte wide)
//   cpu_*                     CPU request/grant/read-return (word wide)
//   mem_*                     RAM data port; read data arrives one cycle
//                             after the read strobe
//   stall_cnt_o               saturating count of CPU stall cycles
module ram_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            host_excl_i,
  input  logic            host_req_i,
  input  logic            host_we_i,
  input  logic [XLEN-1:0] host_addr_i,
  input  logic [7:0]      host_wr_data_i,
  output logic            host_gnt_o,
  output logic [7:0]      host_rd_data_o,
  output logic            host_rd_vld_o,
  input  logic            cpu_req_i,
  input  logic            cpu_we_i,
  input  logic [XLEN-1:0] cpu_addr_i,
  input  logic [XLEN-1:0] cpu_wr_data_i,
  input  logic [3:0]      cpu_byte_en_i,
  output logic            cpu_gnt_o,
  output logic [XLEN-1:0] cpu_rd_data_o,
  output logic            cpu_rd_vld_o,
  output logic            mem_en_o,
  output logic [3:0]      mem_we_o,
  output logic [XLEN-3:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  input  logic [XLEN-1:0] mem_rd_data_i,
  output logic [15:0]     stall_cnt_o
);

  // 1 = the host won the most recent counted transfer.
  logic        last_host;
  logic        last_upd;
  logic        rd_gnt;
  logic        vld_p1;
  logic        rd_host_p1;
  logic [1:0]  rd_lane_p1;
  logic [15:0] stall_cnt;
  logic [1:0]  cpu_addr_unused;

  // Word addressing: the CPU's byte offset is irrelevant to the RAM.
  assign cpu_addr_unused = cpu_addr_i[1:0];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Grants: exclusive mode hands the port to the host outright; otherwise a
  // lone requester wins, and on a tie the loser of the last transfer wins.
  always_comb begin
    host_gnt_o = 1'b0;
    cpu_gnt_o  = 1'b0;
    if (host_excl_i) begin
      host_gnt_o = host_req_i;
    end else begin
      host_gnt_o = host_req_i & (~cpu_req_i | ~last_host);
      cpu_gnt_o  = cpu_req_i  & (~host_req_i | last_host);
    end
  end

  // Uncontested exclusive-mode grants leave the pointer alone so the CPU
  // keeps its place in the rotation once exclusive mode ends.
  assign last_upd = (host_gnt_o | cpu_gnt_o) & ~(host_excl_i & ~cpu_req_i);
  assign rd_gnt   = (host_gnt_o & ~host_we_i) | (cpu_gnt_o & ~cpu_we_i);

  // RAM port steering; with no grant the host fields are presented.
  always_comb begin
    mem_en_o      = host_gnt_o | cpu_gnt_o;
    mem_addr_o    = host_addr_i[XLEN-1:2];
    mem_wr_data_o = {4{host_wr_data_i}};
    mem_we_o      = 4'b0000;
    if (cpu_gnt_o) begin
      mem_addr_o    = cpu_addr_i[XLEN-1:2];
      mem_wr_data_o = cpu_wr_data_i;
      mem_we_o      = cpu_we_i ? cpu_byte_en_i : 4'b0000;
    end else if (host_gnt_o) begin
      mem_we_o = host_we_i ? (4'b0001 << host_addr_i[1:0]) : 4'b0000;
    end
  end

  // ---- stage p0 -> p1: grant edge, read owner captured ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_host  <= 1'b0;
      vld_p1     <= 1'b0;
      rd_host_p1 <= 1'b0;
      stall_cnt  <= 16'd0;
    end else begin
      if (last_upd) begin
        last_host <= host_gnt_o;
      end
      vld_p1     <= rd_gnt;
      rd_host_p1 <= host_gnt_o;
      if (cpu_req_i && !cpu_gnt_o) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    rd_lane_p1 <= host_addr_i[1:0];
  end

  // ---- stage p1: RAM read data returned to its owner ----
  assign host_rd_vld_o  = vld_p1 & rd_host_p1;
  assign cpu_rd_vld_o   = vld_p1 & ~rd_host_p1;
  assign cpu_rd_data_o  = mem_rd_data_i;
  assign host_rd_data_o = mem_rd_data_i[{rd_lane_p1, 3'b000} +: 8];
  assign stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        host_excl_i;
  logic        host_req_i;
  logic        host_we_i;
  logic [31:0] host_addr_i;
  logic [7:0]  host_wr_data_i;
  logic        host_gnt_o;
  logic [7:0]  host_rd_data_o;
  logic        host_rd_vld_o;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wr_data_i;
  logic [3:0]  cpu_byte_en_i;
  logic        cpu_gnt_o;
  logic [31:0] cpu_rd_data_o;
  logic        cpu_rd_vld_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [31:0] mem_rd_data_i = 32'd0;
  logic [15:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        is_host;
    logic [31:0] data;
    int          exp_cyc;
  } rd_exp_t;
  rd_exp_t sb[$];

  logic [31:0] ram [0:255];

  ram_arb #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .host_excl_i    (host_excl_i),
    .host_req_i     (host_req_i),
    .host_we_i      (host_we_i),
    .host_addr_i    (host_addr_i),
    .host_wr_data_i (host_wr_data_i),
    .host_gnt_o     (host_gnt_o),
    .host_rd_data_o (host_rd_data_o),
    .host_rd_vld_o  (host_rd_vld_o),
    .cpu_req_i      (cpu_req_i),
    .cpu_we_i       (cpu_we_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_wr_data_i  (cpu_wr_data_i),
    .cpu_byte_en_i  (cpu_byte_en_i),
    .cpu_gnt_o      (cpu_gnt_o),
    .cpu_rd_data_o  (cpu_rd_data_o),
    .cpu_rd_vld_o   (cpu_rd_vld_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous RAM with byte write enables.
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rd_data_i <= ram[mem_addr_o[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_addr_o[7:0]][b*8 +: 8] <= mem_wr_data_o[b*8 +: 8];
    end
  end

  // Scoreboard: every read return must match the oldest expected entry,
  // arrive in exactly the expected cycle, and nothing may arrive unexpected.
  always @(negedge clk) begin
    rd_exp_t e;
    if (host_rd_vld_o || cpu_rd_vld_o) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: host_vld=%0b cpu_vld=%0b, required no return", host_rd_vld_o, cpu_rd_vld_o);
      end else begin
        e = sb.pop_front();
        if (host_rd_vld_o !== e.is_host || cpu_rd_vld_o !== !e.is_host || cyc != e.exp_cyc ||
            (e.is_host ? (host_rd_data_o !== e.data[7:0]) : (cpu_rd_data_o !== e.data))) begin
          n_fail++;
          $display("FAIL rd_return: host_vld=%0b cpu_vld=%0b hdata=%h cdata=%h cyc=%0d, required host=%0b data=%h cyc=%0d",
                   host_rd_vld_o, cpu_rd_vld_o, host_rd_data_o, cpu_rd_data_o, cyc, e.is_host, e.data, e.exp_cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].exp_cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL rd_missing: no valid at cyc=%0d, required host=%0b data=%h", cyc, e.is_host, e.data);
    end
  end

  task automatic push_rd(input logic is_host, input logic [31:0] data);
    rd_exp_t e;
    e.is_host = is_host;
    e.data    = data;
    e.exp_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    host_excl_i = 0; host_req_i = 0; host_we_i = 0; host_addr_i = 0; host_wr_data_i = 0;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wr_data_i = 0; cpu_byte_en_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_i = 0;
    cpu_req_i = 1; host_excl_i = 1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'd0 || host_rd_vld_o !== 0 || cpu_rd_vld_o !== 0) begin
      n_fail++;
      $display("FAIL reset_state: stall=%h hvld=%b cvld=%b, required 0 0 0", stall_cnt_o, host_rd_vld_o, cpu_rd_vld_o);
    end
    @(negedge clk);
    idle_inputs();
    rst_n_i = 1;
    #1;
    n_tests++;
    if (mem_en_o !== 0 || mem_we_o !== 4'b0 || host_gnt_o !== 0 || cpu_gnt_o !== 0) begin
      n_fail++;
      $display("FAIL idle_port: en=%b we=%b hg=%b cg=%b, required all 0", mem_en_o, mem_we_o, host_gnt_o, cpu_gnt_o);
    end
  endtask

  task automatic test_host_steer();
    logic [3:0] exp_we;
    do_reset();
    @(negedge clk);
    host_req_i = 1; host_we_i = 1; host_addr_i = 32'h106; host_wr_data_i = 8'hAA;
    #1;
    n_tests++;
    if (mem_addr_o !== 30'h41 || mem_we_o !== 4'b0100 || mem_wr_data_o !== 32'hAAAAAAAA ||
        host_gnt_o !== 1 || mem_en_o !== 1) begin
      n_fail++;
      $display("FAIL host_write: addr=%h we=%b data=%h gnt=%b en=%b, required 41 0100 aaaaaaaa 1 1",
               mem_addr_o, mem_we_o, mem_wr_data_o, host_gnt_o, mem_en_o);
    end
    @(negedge clk);
    host_we_i = 0;
    push_rd(1, 32'h000000AA);
    #1;
    n_tests++;
    if (mem_we_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL host_read_we: we=%b, required 0000", mem_we_o);
    end
    for (int l = 0; l < 4; l++) begin
      @(negedge clk);
      host_we_i = 1; host_addr_i = 32'h200 + l; host_wr_data_i = 8'h10 + 8'(l);
      exp_we = 4'(1 << l);
      #1;
      n_tests++;
      if (mem_we_o !== exp_we) begin
        n_fail++;
        $display("FAIL host_lane%0d: we=%b, required %b", l, mem_we_o, exp_we);
      end
    end
    @(negedge clk);
    host_req_i = 0; host_we_i = 0;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h200;
    push_rd(0, 32'h13121110);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_steer();
    do_reset();
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h13; cpu_wr_data_i = 32'h12345678; cpu_byte_en_i = 4'b0101;
    host_addr_i = 32'h3FC; host_wr_data_i = 8'h55;
    #1;
    n_tests++;
    if (mem_addr_o !== 30'h4 || mem_we_o !== 4'b0101 || mem_wr_data_o !== 32'h12345678 ||
        cpu_gnt_o !== 1 || host_gnt_o !== 0) begin
      n_fail++;
      $display("FAIL cpu_write: addr=%h we=%b data=%h cg=%b hg=%b, required 4 0101 12345678 1 0",
               mem_addr_o, mem_we_o, mem_wr_data_o, cpu_gnt_o, host_gnt_o);
    end
    @(negedge clk);
    cpu_we_i = 0; cpu_addr_i = 32'h10;
    push_rd(0, 32'h00340078);
    #1;
    n_tests++;
    if (mem_we_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL cpu_read_we: we=%b, required 0000", mem_we_o);
    end
    @(negedge clk);
    cpu_we_i = 1; cpu_wr_data_i = 32'hFFFFFFFF; cpu_byte_en_i = 4'b1111;
    @(negedge clk);
    cpu_we_i = 0;
    push_rd(0, 32'hFFFFFFFF);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    ram[2] = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      host_req_i = 1; host_we_i = 0; host_addr_i = 32'h9;
      cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h8;
      if (i % 2 == 0) push_rd(1, 32'h000000F0);
      else            push_rd(0, 32'hCAFEF00D);
      #1;
      n_tests++;
      if (host_gnt_o !== (i % 2 == 0) || cpu_gnt_o !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: hg=%b cg=%b, required hg=%b", i, host_gnt_o, cpu_gnt_o, (i % 2 == 0));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'd4) begin
      n_fail++;
      $display("FAIL rr_stall: stall=%0d, required 4", stall_cnt_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_alt_reads();
    do_reset();
    ram[0] = 32'h11223344;
    ram[1] = 32'hDEADBEEF;
    @(negedge clk);
    host_req_i = 1; host_we_i = 0; host_addr_i = 32'h0;
    push_rd(1, 32'h00000044);
    @(negedge clk);
    host_req_i = 0;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h4;
    push_rd(0, 32'hDEADBEEF);
    @(negedge clk);
    cpu_req_i = 0;
    host_req_i = 1; host_addr_i = 32'h3;
    push_rd(1, 32'h00000011);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_excl_stall();
    do_reset();
    @(negedge clk);
    host_excl_i = 1; cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_tests++;
      if (cpu_gnt_o !== 0 || mem_en_o !== 0) begin
        n_fail++;
        $display("FAIL excl_lockout%0d: cg=%b en=%b, required 0 0", i, cpu_gnt_o, mem_en_o);
      end
      @(negedge clk);
    end
    cpu_req_i = 0;
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'd20) begin
      n_fail++;
      $display("FAIL excl_stall: stall=%0d, required 20", stall_cnt_o);
    end
    idle_inputs();
  endtask

  task automatic test_excl_last();
    do_reset();
    ram[1] = 32'hDEADBEEF;
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h4;
    push_rd(0, 32'hDEADBEEF);
    @(negedge clk);
    cpu_req_i = 0;
    host_excl_i = 1; host_req_i = 1; host_we_i = 1; host_addr_i = 32'h300; host_wr_data_i = 8'h5A;
    #1;
    n_tests++;
    if (host_gnt_o !== 1 || cpu_gnt_o !== 0) begin
      n_fail++;
      $display("FAIL excl_host: hg=%b cg=%b, required 1 0", host_gnt_o, cpu_gnt_o);
    end
    @(negedge clk);
    host_excl_i = 0;
    cpu_req_i = 1; cpu_we_i = 1; cpu_byte_en_i = 4'b0000; cpu_addr_i = 32'h304;
    #1;
    n_tests++;
    if (host_gnt_o !== 1 || cpu_gnt_o !== 0) begin
      n_fail++;
      $display("FAIL excl_tie1: hg=%b cg=%b, required 1 0", host_gnt_o, cpu_gnt_o);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (host_gnt_o !== 0 || cpu_gnt_o !== 1) begin
      n_fail++;
      $display("FAIL excl_tie2: hg=%b cg=%b, required 0 1", host_gnt_o, cpu_gnt_o);
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0;
    @(posedge clk);
    #1;
    rst_n_i = 0;
    idle_inputs();
    #1;
    n_tests++;
    if (cpu_rd_vld_o !== 0 || host_rd_vld_o !== 0 || stall_cnt_o !== 16'd0 || mem_en_o !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: cvld=%b hvld=%b stall=%0d en=%b, required 0 0 0 0",
               cpu_rd_vld_o, host_rd_vld_o, stall_cnt_o, mem_en_o);
    end
    @(negedge clk);
    rst_n_i = 1;
    @(negedge clk);
    #1;
    n_tests++;
    if (cpu_rd_vld_o !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_after: cvld=%b, required 0", cpu_rd_vld_o);
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    host_excl_i = 1; cpu_req_i = 1;
    repeat (65534) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL stall_pre: stall=%h, required fffe", stall_cnt_o);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stall_max: stall=%h, required ffff", stall_cnt_o);
    end
    repeat (4465) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stall_hold: stall=%h, required ffff", stall_cnt_o);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    test_reset();
    test_host_steer();
    test_cpu_steer();
    test_round_robin();
    test_alt_reads();
    test_excl_stall();
    test_excl_last();
    test_reset_mid();
    test_stall_sat();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d reads outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
